// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a head register and one skid entry.
// Supports hazard flush (ctrl zeroed, drops counted) and synchronous clear.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CTRL_W-1:0]   head_ctrl_r, head_ctrl_s, skid_ctrl_r, skid_ctrl_s;
    logic [DATA_W-1:0]   head_data_r, head_data_s, skid_data_r, skid_data_s;
    logic [CNT_W-1:0]    drop_cnt_r, drop_cnt_s;
    logic                accept_s, fire_s;
    logic [1:0]          held_s, inc_s;
    logic [CNT_W:0]      sum_s;

    // Handshake and occupancy all decode from the registered state only.
    assign in_ready  = (state_r != TWO);
    assign out_valid = (state_r != EMPTY);
    assign occupancy = {state_r == TWO, state_r == ONE};
    assign out_ctrl  = head_ctrl_r;
    assign out_data  = head_data_r;
    assign drop_cnt  = drop_cnt_r;

    // Next-state, storage update and saturating drop accounting.
    always_comb begin
        state_s     = state_r;
        head_ctrl_s = head_ctrl_r;
        head_data_s = head_data_r;
        skid_ctrl_s = skid_ctrl_r;
        skid_data_s = skid_data_r;
        drop_cnt_s  = drop_cnt_r;
        accept_s    = in_valid & (state_r != TWO);
        fire_s      = (state_r != EMPTY) & out_ready;
        held_s      = {state_r == TWO, state_r == ONE};
        inc_s       = held_s - {1'b0, fire_s} + {1'b0, accept_s};
        sum_s       = {1'b0, drop_cnt_r} + {{(CNT_W-1){1'b0}}, inc_s};
        if (flush) begin
            // Head/skid data are left alone; only ctrl is squashed to a bubble.
            state_s     = EMPTY;
            head_ctrl_s = {CTRL_W{1'b0}};
            skid_ctrl_s = {CTRL_W{1'b0}};
            if (sum_s[CNT_W]) begin
                drop_cnt_s = {CNT_W{1'b1}};
            end else begin
                drop_cnt_s = sum_s[CNT_W-1:0];
            end
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        head_ctrl_s = in_ctrl;
                        head_data_s = in_data;
                        state_s     = ONE;
                    end else begin
                        state_s     = EMPTY;
                    end
                end
                ONE: begin
                    if (fire_s && accept_s) begin
                        head_ctrl_s = in_ctrl;
                        head_data_s = in_data;
                    end else if (fire_s) begin
                        head_ctrl_s = {CTRL_W{1'b0}};
                        state_s     = EMPTY;
                    end else if (accept_s) begin
                        skid_ctrl_s = in_ctrl;
                        skid_data_s = in_data;
                        state_s     = TWO;
                    end else begin
                        state_s     = ONE;
                    end
                end
                TWO: begin
                    if (fire_s) begin
                        head_ctrl_s = skid_ctrl_r;
                        head_data_s = skid_data_r;
                        skid_ctrl_s = {CTRL_W{1'b0}};
                        state_s     = ONE;
                    end else begin
                        state_s     = TWO;
                    end
                end
                default: begin
                    head_ctrl_s = {CTRL_W{1'b0}};
                    skid_ctrl_s = {CTRL_W{1'b0}};
                    state_s     = EMPTY;
                end
            endcase
        end
    end

    // State and storage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= EMPTY;
            head_ctrl_r <= {CTRL_W{1'b0}};
            head_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            head_ctrl_r <= head_ctrl_s;
            head_data_r <= head_data_s;
            skid_ctrl_r <= skid_ctrl_s;
            skid_data_r <= skid_data_s;
            drop_cnt_r  <= drop_cnt_s;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (narrow drop counter
// so saturation is reachable).
module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              clr, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Load two beats with downstream stalled; ends in the two-entry state.
    task automatic fill2(input logic [7:0] a, input logic [7:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = a;
        in_data   = {120'd0, a};
        step();
        in_ctrl   = b;
        in_data   = {120'd0, b};
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = 8'd0; in_data = 128'd0;
        #2;
        pulse_clr();
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_ctrl", out_ctrl, 8'd0);
        check_val("rst_out_data", out_data, 128'd0);
        check_val("rst_occupancy", occupancy, 2'd0);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_drop_cnt", drop_cnt, 2'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'(i + 16);
            in_data  = 128'(i);
            step();
            check_val("stream_valid", out_valid, 1'b1);
            check_val("stream_data", out_data, 128'(i));
            check_val("stream_ctrl", out_ctrl, 128'(i + 16));
            check_val("stream_in_ready", in_ready, 1'b1);
            check_val("stream_occ", occupancy, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_val("stream_drain_valid", out_valid, 1'b0);
        check_val("stream_drain_ctrl", out_ctrl, 8'd0);

        // Backpressure: A,B held, C waits upstream
        fill2(8'hA1, 8'hB2);
        check_val("bp_occ", occupancy, 2'd2);
        check_val("bp_in_ready", in_ready, 1'b0);
        check_val("bp_head", out_data, 128'hA1);
        in_valid = 1'b1; in_ctrl = 8'hC3; in_data = 128'hC3;
        step();
        check_val("bp_stable_data", out_data, 128'hA1);
        check_val("bp_stable_ctrl", out_ctrl, 8'hA1);
        check_val("bp_occ_hold", occupancy, 2'd2);
        out_ready = 1'b1;
        step();
        check_val("bp_second", out_data, 128'hB2);
        check_val("bp_occ_one", occupancy, 2'd1);
        step();
        check_val("bp_third", out_data, 128'hC3);
        check_val("bp_third_ctrl", out_ctrl, 8'hC3);
        in_valid = 1'b0;
        step();
        check_val("bp_empty", out_valid, 1'b0);

        // Flush in TWO with nothing firing
        fill2(8'h21, 8'h22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("fl2_valid", out_valid, 1'b0);
        check_val("fl2_ctrl", out_ctrl, 8'd0);
        check_val("fl2_occ", occupancy, 2'd0);
        check_val("fl2_cnt", drop_cnt, 2'd2);
        check_val("fl2_data_hold", out_data, 128'h21);

        // Flush in ONE with fire and accept
        pulse_clr();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h41; in_data = 128'h41;
        step();
        out_ready = 1'b1; in_ctrl = 8'h5D; in_data = 128'h5D; flush = 1'b1;
        check_val("fl1_deliver_valid", out_valid, 1'b1);
        check_val("fl1_deliver_data", out_data, 128'h41);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_val("fl1_cnt", drop_cnt, 2'd1);
        check_val("fl1_occ", occupancy, 2'd0);
        check_val("fl1_valid", out_valid, 1'b0);
        check_val("fl1_data_hold", out_data, 128'h41);

        // Flush with EMPTY and no accept: no count change
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("fl0_cnt", drop_cnt, 2'd1);
        check_val("fl0_occ", occupancy, 2'd0);

        // Saturation of the 2-bit counter
        pulse_clr();
        fill2(8'h61, 8'h62);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("sat_cnt_2", drop_cnt, 2'd2);
        fill2(8'h63, 8'h64);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("sat_cnt_3", drop_cnt, 2'd3);
        fill2(8'h65, 8'h66);
        flush = 1'b1; step(); flush = 1'b0;
        check_val("sat_cnt_hold", drop_cnt, 2'd3);

        // clr in TWO with in_valid high
        fill2(8'h71, 8'h72);
        in_valid = 1'b1; in_ctrl = 8'h73; in_data = 128'h73;
        clr = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0;
        check_val("clr2_valid", out_valid, 1'b0);
        check_val("clr2_ctrl", out_ctrl, 8'd0);
        check_val("clr2_data", out_data, 128'd0);
        check_val("clr2_occ", occupancy, 2'd0);
        check_val("clr2_in_ready", in_ready, 1'b1);
        check_val("clr2_cnt", drop_cnt, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, 8, width of control field; zeroed on flush, reset and bubble.
REQ-002 Parameter DATA_W, 128, width of data field; not zeroed on flush.
REQ-003 Parameter CNT_W, 16, width of flush-drop counter.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port clr  input  1  synchronous active-high reset; highest priority.
REQ-006 Port flush  input  1  synchronous discard of all held entries (hazard bubble insertion).
REQ-007 Port in_valid  input  1  upstream beat present.
REQ-008 Port in_ready  output  1  stage can accept a beat this cycle.
REQ-009 Port in_ctrl  input  CTRL_W  upstream control field.
REQ-010 Port in_data  input  DATA_W  upstream data field (operands, immediates, register indices).
REQ-011 Port out_valid  output  1  downstream beat present.
REQ-012 Port out_ready  input  1  downstream accepts beat.
REQ-013 Port out_ctrl  output  CTRL_W  control field of head entry; all zero whenever out_valid=0.
REQ-014 Port out_data  output  DATA_W  data field of head entry.
REQ-015 Port occupancy  output  2  number of held entries, 0..2.
REQ-016 Port drop_cnt  output  CNT_W  count of entries discarded by flush, saturating.

Function
REQ-017 Storage: head register (drives outputs) plus one skid register; states EMPTY (0 entries), ONE (head valid), TWO (head and skid valid).
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, derived only from registered state (no combinational path from out_ready or in_valid).
REQ-019 accept = in_valid & in_ready; fire = out_valid & out_ready; out_valid = (state != EMPTY).
REQ-020 EMPTY: accept -> head<=in, ONE; else stay EMPTY.
REQ-021 ONE: fire & accept -> head<=in, stay ONE; fire & !accept -> EMPTY; !fire & accept -> skid<=in, TWO; neither -> hold.
REQ-022 TWO: fire -> head<=skid, ONE; !fire -> hold; no input accepted.
REQ-023 Latency: an accepted beat into EMPTY, or into ONE with fire, appears on out_* the following cycle; full throughput of one beat per cycle while out_ready=1.
REQ-024 Beats leave in acceptance order; no beat duplicated or lost except by flush or clr.
REQ-025 out_ctrl/out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 flush (clr=0): next state EMPTY; ctrl fields of head and skid zeroed; data fields hold; an input beat accepted in the flush cycle is discarded; fire in the flush cycle still counts as delivered downstream.
REQ-027 drop_cnt increments at a flush by the number of entries held that cycle that did not fire plus 1 if an input beat was accepted; saturates at 2^CNT_W-1, never wraps.
REQ-028 occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-029 flush with state EMPTY and no accept: no counter change; state stays EMPTY.

Reset
REQ-030 clr=1 at a rising edge: state EMPTY, head and skid ctrl and data all zero, drop_cnt=0; all other inputs ignored that cycle.
REQ-031 After clr: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-032 clr mid-operation (state TWO) SHALL discard both entries without incrementing drop_cnt.

Verification
REQ-033 Streaming: out_ready=1, 8 beats data=1..8 back-to-back -> out_data 1..8 on consecutive cycles, one cycle after input, in_ready stays 1.
REQ-034 Backpressure: beats A,B with out_ready=0 -> occupancy 2, in_ready=0, C held upstream; out_ready=1 -> A, B, C delivered in order, none lost.
REQ-035 Flush in TWO, out_ready=0, in_valid=0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, drop_cnt +2.
REQ-036 Flush in ONE with fire and accept same cycle -> head delivered, input dropped, drop_cnt +1, state EMPTY.
REQ-037 CNT_W=2, repeated flushes of 2 entries -> drop_cnt saturates at 3.
REQ-038 clr asserted in TWO with in_valid=1 -> next cycle all outputs zero, in_ready=1, drop_cnt=0.
